imem_loader: RTL and testbench

Instruction-memory responder for the single-cycle CPU fetch port: returns a 32-bit instruction word combinationally for the CPU's fetch address. At power-up it first accepts a program as a byte stream over a valid/ready load port, packs bytes little-endian into words, and holds the CPU in reset until loading completes. It sits between the testbench/boot source and the CPU's fetch interface.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_byte_packer.sv | 60 ++++++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
//   state_t          - loader mode (LOAD, RUN, ERROR)
//   NOP_WORD_DEFAULT - instruction returned for any fetch that does not hit
//                      loaded program memory (addi x0,x0,0)
//   lane_t           - byte-lane index inside a 32-bit word
package imem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef logic [1:0] lane_t;

  localparam lane_t LAST_LANE = 2'd3;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles a little-endian 32-bit word from a byte stream.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   beat        - a byte is accepted this cycle
//   data        - the accepted byte
//   last        - the accepted byte is the final one of the program
//   word        - word to store: previously collected lanes, the current
//                 byte in its lane, and zeros in every lane above it
//   word_strobe - word is complete (lane 3 filled or last byte) this beat
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_strobe
);

  lane_t       lane_r;
  logic [31:0] asm_r;

  // Merge the incoming byte into the collected lanes; upper lanes read as zero
  // so a short final word is padded without an extra cycle.
  always_comb begin
    word = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (lane_t'(i) < lane_r) begin
        word[8*i +: 8] = asm_r[8*i +: 8];
      end else if (lane_t'(i) == lane_r) begin
        word[8*i +: 8] = data;
      end else begin
        word[8*i +: 8] = 8'h00;
      end
    end
    word_strobe = beat && ((lane_r == LAST_LANE) || last);
  end

  // Lane counter and assembly register; both restart after a word is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r <= 2'd0;
      asm_r  <= 32'h0000_0000;
    end else if (beat) begin
      if (word_strobe) begin
        lane_r <= 2'd0;
        asm_r  <= 32'h0000_0000;
      end else begin
        lane_r <= lane_r + 2'd1;
        asm_r  <= word;
      end
    end else begin
      lane_r <= lane_r;
      asm_r  <= asm_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory for a single-cycle CPU fetch port, filled
// at power-up from a byte stream. The CPU is held in reset until the final
// program byte has been stored.
// Ports:
//   i_clock, i_resetn - clock, asynchronous active-low reset
//   i_imemAddr        - CPU fetch byte address
//   o_imemData        - fetched word (combinational); NOP_WORD on miss
//   i_loadValid/o_loadReady/i_loadByte/i_loadLast - byte load handshake
//   o_loadDone        - program loaded, fetches served from memory
//   o_loadError       - program longer than memory, sticky until reset
//   o_cpuResetn       - registered active-low CPU reset, high only in RUN
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic [31:0] i_imemAddr,
  output logic [31:0] o_imemData,
  input  logic        i_loadValid,
  output logic        o_loadReady,
  input  logic [7:0]  i_loadByte,
  input  logic        i_loadLast,
  output logic        o_loadDone,
  output logic        o_loadError,
  output logic        o_cpuResetn
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so the pointer can hold DEPTH (memory full).
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_PTR = PW'(DEPTH);

  state_t          state_r;
  state_t          next_state_s;
  logic [PW-1:0]   word_ptr_r;
  logic [PW-1:0]   word_count_r;
  logic [31:0]     mem [DEPTH];

  logic            ready_r;
  logic            done_r;
  logic            error_r;
  logic            cpu_resetn_r;

  logic            beat_s;
  logic            full_s;
  logic            mem_we_s;
  logic [31:0]     pack_word_s;
  logic            pack_strobe_s;
  logic [AW-1:0]   fetch_idx_s;
  logic            fetch_hit_s;

  assign beat_s = i_loadValid && ready_r;

  imem_byte_packer u_packer (
    .clk         (i_clock),
    .rst_n       (i_resetn),
    .beat        (beat_s),
    .data        (i_loadByte),
    .last        (i_loadLast),
    .word        (pack_word_s),
    .word_strobe (pack_strobe_s)
  );

  // Next-state and memory write enable. Once memory is full any further byte
  // is an overflow, since it would need a word slot that does not exist.
  always_comb begin
    next_state_s = state_r;
    mem_we_s     = 1'b0;
    full_s       = (word_ptr_r == FULL_PTR);
    case (state_r)
      ST_LOAD: begin
        if (beat_s && full_s) begin
          next_state_s = ST_ERROR;
        end else if (beat_s && i_loadLast) begin
          next_state_s = ST_RUN;
          mem_we_s     = 1'b1;
        end else if (beat_s && pack_strobe_s) begin
          next_state_s = ST_LOAD;
          mem_we_s     = 1'b1;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_RUN:   next_state_s = ST_RUN;
      ST_ERROR: next_state_s = ST_ERROR;
      default:  next_state_s = ST_LOAD;
    endcase
  end

  // State, word pointers and registered status outputs decoded from the
  // next state so they change cleanly on the same edge as the state.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state_r      <= ST_LOAD;
      word_ptr_r   <= '0;
      word_count_r <= '0;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cpu_resetn_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (mem_we_s) begin
        word_ptr_r   <= word_ptr_r + PW'(1);
        word_count_r <= word_ptr_r + PW'(1);
      end else begin
        word_ptr_r   <= word_ptr_r;
        word_count_r <= word_count_r;
      end
      ready_r      <= (next_state_s == ST_LOAD);
      done_r       <= (next_state_s == ST_RUN);
      error_r      <= (next_state_s == ST_ERROR);
      cpu_resetn_r <= (next_state_s == ST_RUN);
    end
  end

  // Program storage; deliberately not reset, stale words are hidden by
  // word_count_r.
  always_ff @(posedge i_clock) begin
    if (mem_we_s) begin
      mem[word_ptr_r[AW-1:0]] <= pack_word_s;
    end
  end

  // Fetch port: serve only aligned, in-range, loaded words while running.
  always_comb begin
    fetch_idx_s = i_imemAddr[2 +: AW];
    fetch_hit_s = (state_r == ST_RUN)
               && (i_imemAddr[1:0] == 2'b00)
               && (i_imemAddr[31:AW+2] == '0)
               && ({1'b0, fetch_idx_s} < word_count_r);
    if (fetch_hit_s) begin
      o_imemData = mem[fetch_idx_s];
    end else begin
      o_imemData = NOP_WORD;
    end
  end

  assign o_loadReady = ready_r;
  assign o_loadDone  = done_r;
  assign o_loadError = error_r;
  assign o_cpuResetn = cpu_resetn_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (DEPTH=256 and DEPTH=4).
// Stimulus pushes expected values from a byte-list reference model into a
// queue; a monitor drains the queue on each falling clock edge.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Big instance (DEPTH=256)
  logic        rstn_b, valid_b, last_b, ready_b, done_b, err_b, cpurst_b;
  logic [7:0]  byte_b;
  logic [31:0] addr_b, data_b;
  // Small instance (DEPTH=4)
  logic        rstn_s, valid_s, last_s, ready_s, done_s, err_s, cpurst_s;
  logic [7:0]  byte_s;
  logic [31:0] addr_s, data_s;

  imem_loader #(.DEPTH(256)) dut_big (
    .i_clock(clk), .i_resetn(rstn_b), .i_imemAddr(addr_b), .o_imemData(data_b),
    .i_loadValid(valid_b), .o_loadReady(ready_b), .i_loadByte(byte_b),
    .i_loadLast(last_b), .o_loadDone(done_b), .o_loadError(err_b),
    .o_cpuResetn(cpurst_b)
  );

  imem_loader #(.DEPTH(4)) dut_small (
    .i_clock(clk), .i_resetn(rstn_s), .i_imemAddr(addr_s), .o_imemData(data_s),
    .i_loadValid(valid_s), .o_loadReady(ready_s), .i_loadByte(byte_s),
    .i_loadLast(last_s), .o_loadDone(done_s), .o_loadError(err_s),
    .o_cpuResetn(cpurst_s)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          sel;   // 0 big data, 1 big status, 2 small data, 3 small status
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  chk_t        mon_c;
  logic [31:0] mon_act;

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        mon_c = q.pop_front();
        case (mon_c.sel)
          0:       mon_act = data_b;
          1:       mon_act = {28'h0, done_b, ready_b, err_b, cpurst_b};
          2:       mon_act = data_s;
          default: mon_act = {28'h0, done_s, ready_s, err_s, cpurst_s};
        endcase
        tests_run++;
        if (mon_act !== mon_c.exp) begin
          tests_failed++;
          $display("FAIL %s: got %h expected %h", mon_c.name, mon_act, mon_c.exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Program = ordered list of accepted bytes; mode 0 loading, 1 running, 2 error.
  int          cur = 0;
  int unsigned mdepth = 256;
  int          mstate = 0;
  logic [7:0]  mbytes[$];

  function automatic void model_reset();
    mbytes.delete();
    mstate = 0;
    mdepth = (cur == 0) ? 256 : 4;
  endfunction

  function automatic void model_beat(input logic [7:0] b, input logic l);
    if (mstate == 0) begin
      if (mbytes.size() == mdepth * 4) begin
        mstate = 2;
      end else begin
        mbytes.push_back(b);
        if (l) mstate = 1;
      end
    end
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    int unsigned idx;
    logic [31:0] w;
    if (mstate != 1 || a[1:0] != 2'b00 || a >= 32'(mdepth * 4)) return NOP;
    idx = a / 4;
    if (idx * 4 >= mbytes.size()) return NOP;
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      if (idx * 4 + k < mbytes.size()) w = w | (32'(mbytes[idx * 4 + k]) << (8 * k));
    return w;
  endfunction

  function automatic logic [31:0] model_status();
    // {done, ready, error, cpu_resetn}
    case (mstate)
      0:       return 32'h4;
      1:       return 32'h9;
      default: return 32'h2;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] b, input logic l);
    if (cur == 0) begin valid_b = v; byte_b = b; last_b = l; end
    else          begin valid_s = v; byte_s = b; last_s = l; end
  endtask

  task automatic set_addr(input logic [31:0] a);
    if (cur == 0) addr_b = a; else addr_s = a;
  endtask

  task automatic set_rstn(input logic r);
    if (cur == 0) rstn_b = r; else rstn_s = r;
  endtask

  task automatic check_status(input string name);
    q.push_back('{name, cur * 2 + 1, model_status()});
  endtask

  task automatic check_fetch(input string name, input logic [31:0] a);
    set_addr(a);
    q.push_back('{name, cur * 2, model_fetch(a)});
    @(negedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    drive(1'b1, b, l);
    model_beat(b, l);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic gap(input logic l);
    drive(1'b0, 8'($urandom), l);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    set_rstn(1'b0);
    model_reset();
    @(posedge clk); #1;
    check_status("reset_status");
    @(negedge clk); #1;
    set_rstn(1'b1);
    @(posedge clk); #1;
  endtask

  task automatic random_load(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99, 0) < gap_pct) gap(1'($urandom));
      send_byte(8'($urandom), i == n - 1);
    end
    check_status("rand_load_status");
  endtask

  task automatic random_fetches(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = 32'($urandom_range(mbytes.size() / 4 + 2, 0)) * 32'd4;
      if ($urandom_range(3, 0) == 0) a = a + 32'($urandom_range(3, 1));
      if ($urandom_range(7, 0) == 0) a = 32'($urandom);
      check_fetch("rand_fetch", a);
    end
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] prog6 [6];
  logic [7:0] prog1 [4];

  initial begin
    rstn_b = 1'b0; valid_b = 1'b0; last_b = 1'b0; byte_b = 8'h00; addr_b = 32'h0;
    rstn_s = 1'b0; valid_s = 1'b0; last_s = 1'b0; byte_s = 8'h00; addr_s = 32'h0;
    prog6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    prog1 = '{8'h13, 8'h05, 8'h10, 8'h00};

    cur = 1; do_reset();
    cur = 0; do_reset();
    check_fetch("reset_fetch0", 32'h0);

    // addi a0,x0,1 : one full word
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_fetch("load_phase_fetch0", 32'h0);
      send_byte(prog1[i], i == 3);
    end
    check_status("word1_done");
    check_fetch("word1_fetch0", 32'h0);
    check_fetch("word1_fetch4", 32'h4);

    // six bytes: one full and one padded word, plus miss cases
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(prog6[i], i == 5);
    check_status("six_done");
    check_fetch("six_fetch0", 32'h0);
    check_fetch("six_fetch4", 32'h4);
    check_fetch("six_fetch8", 32'h8);
    check_fetch("misaligned2", 32'h2);
    check_fetch("misaligned5", 32'h5);
    check_fetch("out_of_range400", 32'h400);
    check_fetch("unloaded_3fc", 32'h3FC);
    check_fetch("far_addr", 32'h1000_0000);
    for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b1);
    check_status("run_ignores_load");
    check_fetch("run_ignores_fetch4", 32'h4);

    // reset in the middle of a load
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0);
    do_reset();
    check_fetch("after_midreset_fetch0", 32'h0);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), i == 3);
    check_status("midreset_done");
    check_fetch("midreset_fetch0", 32'h0);
    check_fetch("midreset_fetch4", 32'h4);

    // valid toggling with last held high during idle cycles
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        gap(1'b1);
        check_status("gap_last_ignored");
      end
      send_byte(8'($urandom), i == 8);
    end
    check_status("toggle_done");
    for (int w = 0; w < 4; w++) check_fetch("toggle_fetch", 32'(w * 4));

    // randomized programs on the big instance
    for (int r = 0; r < 12; r++) begin
      do_reset();
      random_load($urandom_range(40, 1), 30);
      random_fetches(10);
    end

    // small instance: overflow behaviour
    cur = 1; do_reset();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b0);
      if (i == 15) check_status("small_full_still_loading");
    end
    check_status("small_overflow_error");
    send_byte(8'hEE, 1'b1);
    check_status("small_error_sticky");
    check_fetch("small_error_fetch0", 32'h0);

    // small instance: exactly full program
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), i == 15);
    check_status("small_exact_done");
    for (int w = 0; w < 5; w++) check_fetch("small_exact_fetch", 32'(w * 4));

    for (int r = 0; r < 10; r++) begin
      do_reset();
      random_load($urandom_range(20, 1), 20);
      random_fetches(6);
    end

    @(negedge clk); #1;
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
